// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX datapath among NUM_REQ byte sources.
// Request sampled at edge k gives tx_start/req_ack in cycle k+1; no arbitration while tx_busy or a frame is in flight.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [2:0]             grant_id,
  output logic                   arb_busy,
  output logic                   timeout_err,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t          state;
  logic [2:0]      last_grant;
  logic [TW-1:0]   timer;

  logic [7:0]      valid8;
  logic [63:0]     data64;
  logic [2:0]      cand;
  logic            sel_found;
  logic [2:0]      sel_idx;
  logic [7:0]      sel_byte;
  logic [7:0]      sel_onehot;

  // Widen to the 8-requester maximum so 3-bit indices select exactly.
  always_comb begin
    valid8    = 8'(req_valid);
    data64    = 64'(req_data);
    cand      = 3'd0;
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = 3'((int'(last_grant) + off) % NUM_REQ);
      if (!sel_found && valid8[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_byte   = data64[{sel_idx, 3'b000} +: 8];
    sel_onehot = 8'd1 << sel_idx;
  end

  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      timer       <= '0;
      last_grant  <= 3'(NUM_REQ - 1);
    end else begin
      req_ack  <= '0;
      tx_start <= 1'b0;
      if (err_clr)
        timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && sel_found) begin
            tx_data  <= sel_byte;
            grant_id <= sel_idx;
            req_ack  <= sel_onehot[NUM_REQ-1:0];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done pulse on the last watchdog cycle still counts as a good frame.
          if (tx_done) begin
            frame_cnt  <= frame_cnt + CNT_W'(1);
            last_grant <= grant_id;
            state      <= IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter (4 requesters, watchdog of 8, 4-bit frame counter).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_busy;
  logic        tx_done;
  logic        err_clr;
  logic [3:0]  req_valid;
  logic [3:0]  req_ack;
  logic [3:0]  pend_t;
  logic [3:0]  ack_t = 4'd0;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [2:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;
  logic [3:0]  frame_cnt;

  typedef struct {
    int         id;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   mode_q[$];

  int checks     = 0;
  int errors     = 0;
  int n_frames   = 0;
  int n_timeouts = 0;
  int frame_base = 0;
  int to_at_clr  = 0;
  int model_last = 3;

  // A requester's valid is up between its raise toggle and its ack toggle.
  assign req_valid = pend_t ^ ack_t;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_id(grant_id), .arb_busy(arb_busy),
    .timeout_err(timeout_err), .err_clr(err_clr), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: serve the raised set in round-robin order starting after the last grant.
  task automatic raise(input logic [3:0] mask, input logic [31:0] data);
    logic [3:0] m;
    int last;
    @(posedge clk); #1;
    m = mask;
    last = model_last;
    req_data = data;
    while (m != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (last + k) % 4;
        if (m[i]) begin
          exp_q.push_back('{i, data[8*i +: 8]});
          m[i] = 1'b0;
          last = i;
          break;
        end
      end
    end
    model_last = last;
    pend_t = pend_t ^ mask;
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 100);
    chk("start_seen", 32'(tx_start), 32'd1);
  endtask

  task automatic finish_phase(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid == 4'd0 && !arb_busy && exp_q.size() == 0 && !tx_done) && n < 300);
    chk({tag, "_complete"}, 32'(n < 300), 32'd1);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'((n_frames - frame_base) % 16));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(n_timeouts != to_at_clr));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(model_last));
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    to_at_clr = n_timeouts;
    @(negedge clk);
    chk("err_clear", 32'(timeout_err), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Requesters withdraw on the cycle after their ack.
  initial begin
    logic [3:0] a;
    forever begin
      @(negedge clk);
      a = req_ack;
      @(posedge clk); #1;
      ack_t = ack_t ^ a;
    end
  end

  // Transmitter: done after d cycles (1..8, 8 ties the watchdog) or never (d == 0).
  initial begin
    int d;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (mode_q.size() != 0) d = mode_q.pop_front();
        else d = int'($urandom_range(0, 8));
        if (d == 0) begin
          n_timeouts++;
        end else begin
          repeat (d) @(posedge clk);
          #1 tx_done = 1'b1;
          n_frames++;
          @(posedge clk);
          // Occasionally hold done into the IDLE cycle, where it must be ignored.
          #1 tx_done = ($urandom_range(0, 3) == 0);
          if (tx_done) begin
            @(posedge clk); #1 tx_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every start is matched against the reference order.
  initial begin
    exp_t e;
    logic [7:0] cur_byte = 8'd0;
    logic cur_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(tx_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("tx_data", 32'(tx_data), 32'(e.dat));
          chk("req_ack", 32'(req_ack), 32'd1 << e.id);
          cur_byte = e.dat;
          cur_vld = 1'b1;
        end
      end else begin
        chk("ack_idle", 32'(req_ack), 32'd0);
        if (arb_busy && cur_vld)
          chk("tx_data_hold", 32'(tx_data), 32'(cur_byte));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int starts;
    reset = 1'b1; tx_busy = 1'b0; err_clr = 1'b0;
    pend_t = 4'd0; req_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Single request, byte changed after selection.
    mode_q.push_back(5);
    raise(4'b0001, 32'h0000_00A5);
    wait_start();
    @(posedge clk); #1 req_data = 32'd0;
    finish_phase("single");

    // Round robin over all four, then wrap back to requester 0.
    repeat (4) mode_q.push_back(3);
    raise(4'b1111, $urandom());
    finish_phase("rr_all");
    mode_q.push_back(3);
    raise(4'b0001, $urandom());
    finish_phase("rr_wrap");

    // Fairness after a skip: last grant 1, then 3 before 0.
    raise(4'b0010, $urandom());
    finish_phase("fair_a");
    raise(4'b1001, $urandom());
    finish_phase("fair_b");

    // Busy hold-off.
    @(posedge clk); #1 tx_busy = 1'b1;
    mode_q.push_back(2);
    raise(4'b0010, $urandom());
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      starts += int'(tx_start);
    end
    chk("busy_holdoff", 32'(starts), 32'd0);
    @(posedge clk); #1 tx_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_t", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("busy_release_t1", 32'(tx_start), 32'd1);
    finish_phase("busy");

    // Watchdog: first grant stalls, flag rises after 8 wait cycles, next one served.
    clear_err();
    mode_q.push_back(0);
    mode_q.push_back(2);
    raise(4'b0101, $urandom());
    wait_start();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("wd_not_yet", 32'(timeout_err), 32'd0);
    end
    @(negedge clk);
    chk("wd_set", 32'(timeout_err), 32'd1);
    chk("wd_frame_cnt", 32'(frame_cnt), 32'((n_frames - frame_base) % 16));
    finish_phase("watchdog");
    clear_err();

    // Clear and new timeout in the same cycle: set wins.
    mode_q.push_back(0);
    raise(4'b0001, $urandom());
    finish_phase("wd_again");
    mode_q.push_back(0);
    raise(4'b0010, $urandom());
    wait_start();
    repeat (8) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("set_wins", 32'(timeout_err), 32'd1);
    finish_phase("set_wins");

    // Done on the last watchdog cycle counts as a frame.
    clear_err();
    mode_q.push_back(8);
    raise(4'b0100, $urandom());
    finish_phase("tie");

    // Reset during WAIT_DONE.
    mode_q.push_back(0);
    raise(4'b1000, $urandom());
    wait_start();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_last = 3;
    frame_base = n_frames;
    to_at_clr = n_timeouts;
    @(negedge clk);
    check_reset_values("mid_reset");

    // Random traffic; the 4-bit frame counter wraps several times.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 2) == 0) clear_err();
      raise(4'($urandom_range(1, 15)), $urandom());
      finish_phase("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
